// File: rtl/wb_select_stage_if.sv
// wb_select_stage_if: handshake and data bundle of the writeback select stage.
//   Upstream side : in_valid, in_ready, sel, src, in_reg, in_we
//   Downstream    : out_valid, out_ready, out_data, out_reg, out_we
//   Status        : sel_err (sticky out-of-range select)
// Modports: master = the side driving requests and consuming results
//           slave  = the stage itself
// Parameters must match those of the wb_select_stage instance it connects to.
interface wb_select_stage_if #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 6,
  parameter int SEL_W  = 3,
  parameter int REG_W  = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [N_SRC*DATA_W-1:0] src;
  logic [REG_W-1:0]        in_reg;
  logic                    in_we;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [REG_W-1:0]        out_reg;
  logic                    out_we;
  logic                    sel_err;

  modport master (
    output in_valid, sel, src, in_reg, in_we, out_ready,
    input  in_ready, out_valid, out_data, out_reg, out_we, sel_err
  );

  modport slave (
    input  in_valid, sel, src, in_reg, in_we, out_ready,
    output in_ready, out_valid, out_data, out_reg, out_we, sel_err
  );
endinterface

// File: rtl/wb_select_stage.sv
// wb_select_stage: writeback source select with a two-entry output buffer
// (output register + skid register), one cycle latency.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : wb_select_stage_if.slave (request in, result out, sel_err)
// Optional feature macro: WB_ZERO_REG_GUARD_EN -- entries targeting register 0
// are stored with the write enable cleared.
module wb_select_stage #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 6,
  parameter int SEL_W  = 3,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_select_stage_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              we;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q;
  entry_t out_q, skid_q, in_entry;
  logic   out_valid_q, in_ready_q, sel_err_q;
  logic   sel_oob, accept, consume;

  // Unmatched select values fall through to the all-zero default.
  always_comb begin
    in_entry = '0;
    for (int k = 0; k < N_SRC; k++)
      if (bus.sel == SEL_W'(k)) in_entry.data = bus.src[k*DATA_W +: DATA_W];
    in_entry.rd = bus.in_reg;
`ifdef WB_ZERO_REG_GUARD_EN
    in_entry.we = bus.in_we && (bus.in_reg != '0);
`else
    in_entry.we = bus.in_we;
`endif
  end

  // One extra bit so N_SRC == 2**SEL_W is representable.
  assign sel_oob = {1'b0, bus.sel} >= (SEL_W+1)'(N_SRC);
  assign accept  = bus.in_valid && in_ready_q;
  assign consume = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      sel_err_q   <= 1'b0;
    end else begin
      if (accept && sel_oob) sel_err_q <= 1'b1;
      case (state_q)
        EMPTY: if (accept) begin
          out_q       <= in_entry;
          out_valid_q <= 1'b1;
          state_q     <= ONE;
        end
        ONE: begin
          if (accept && !consume) begin
            skid_q     <= in_entry;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (accept && consume) begin
            out_q <= in_entry;
          end else if (consume) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: if (consume) begin
          // in_ready is low here, so only the skid entry can advance.
          out_q      <= skid_q;
          in_ready_q <= 1'b1;
          state_q    <= ONE;
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q.data;
  assign bus.out_reg   = out_q.rd;
  assign bus.out_we    = out_q.we;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/wb_select_stage.md
WB_SELECT_STAGE -- requirements
Module: wb_select_stage

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, width of each source and of the result.
REQ-002 The module SHALL have parameter N_SRC, default 6, number of data sources (legal range 2..8).
REQ-003 The module SHALL have parameter SEL_W, default 3, select width; N_SRC SHALL be at most 2**SEL_W.
REQ-004 The module SHALL have parameter REG_W, default 5, destination register address width.
REQ-005 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-007 The module SHALL have port in_valid, input, 1, upstream holds a valid writeback request.
REQ-008 The module SHALL have port in_ready, output, 1, stage accepts a request this cycle.
REQ-009 The module SHALL have port sel, input, SEL_W, source index: 0=IO, 1=PC+1, 2=rs data, 3=data mem, 4=ALU, 5=extender, others as instantiated.
REQ-010 The module SHALL have port src, input, N_SRC*DATA_W, concatenated sources; source k occupies slice k.
REQ-011 The module SHALL have port in_reg, input, REG_W, destination register.
REQ-012 The module SHALL have port in_we, input, 1, register-write enable of the request.
REQ-013 The module SHALL have port out_valid, output, 1, registered result valid.
REQ-014 The module SHALL have port out_ready, input, 1, register bank consumes the result.
REQ-015 The module SHALL have port out_data, output, DATA_W, selected data.
REQ-016 The module SHALL have port out_reg, output, REG_W, destination register.
REQ-017 The module SHALL have port out_we, output, 1, write enable toward the register bank.
REQ-018 The module SHALL have port sel_err, output, 1, sticky flag: an accepted request had sel >= N_SRC.

Function
REQ-019 A request SHALL be accepted on a cycle where in_valid and in_ready are both high; a result SHALL be consumed when out_valid and out_ready are both high.
REQ-020 On acceptance, data SHALL be src slice sel when sel < N_SRC, and all zeros otherwise.
REQ-021 An accepted request with sel >= N_SRC SHALL set sel_err the next cycle; sel_err SHALL stay set until reset.
REQ-022 Latency SHALL be exactly one cycle: a request accepted into an empty stage appears on the outputs the next cycle.
REQ-023 The stage SHALL be an output register plus one skid register, giving a capacity of two entries.
REQ-024 in_ready SHALL be registered and SHALL equal NOT skid_full.
REQ-025 The stage SHALL have three states: EMPTY, ONE (output register only) and FULL (output and skid registers).
REQ-026 EMPTY: accept -> ONE.
REQ-027 ONE: accept without consume -> FULL; accept with consume -> ONE holding the new entry; consume without accept -> EMPTY.
REQ-028 FULL: consume -> ONE, with the skid entry moved to the output register; no accept is possible because in_ready is low.
REQ-029 Outputs SHALL hold stable while out_valid is high and out_ready is low.
REQ-030 Entries SHALL leave in acceptance order, with none dropped or duplicated.

Reset
REQ-031 While rst_n is low at a rising clk edge, the stage SHALL go to EMPTY: out_valid=0, in_ready=1, out_data=0, out_reg=0, out_we=0, sel_err=0.
REQ-032 A reset mid-operation SHALL discard both entries; any handshake in that cycle SHALL be ignored.

Configuration
REQ-033 Macro WB_ZERO_REG_GUARD_EN defined: an accepted entry with in_reg=0 SHALL be stored with out_we=0, while data and reg pass unchanged.
REQ-034 Macro WB_ZERO_REG_GUARD_EN undefined: out_we SHALL equal in_we of the entry.

Verification
REQ-035 The bench SHALL cover: reset, then in_valid=1, sel=4, ALU slice=0x0000_00AA, in_reg=3, in_we=1 -> the next cycle out_valid=1, out_data=0x0000_00AA, out_reg=3, out_we=1.
REQ-036 The bench SHALL cover: out_ready=0 with three back-to-back requests (sel=0,1,2) -> the first two are accepted, in_ready=0 after the second, out_data stays equal to the sel=0 source, and order is preserved after out_ready=1.
REQ-037 The bench SHALL cover: sel=7 with N_SRC=6 -> out_data=0 and sel_err=1 one cycle later, still 1 after 10 cycles.
REQ-038 The bench SHALL cover: ONE state with accept and consume in the same cycle -> the new entry is on the outputs the next cycle, with no bubble and no loss.
REQ-039 The bench SHALL cover: FULL, then rst_n=0 for one cycle -> out_valid=0, in_ready=1, sel_err=0.
REQ-040 The bench SHALL cover: in_reg=0, in_we=1 -> out_we=0 with WB_ZERO_REG_GUARD_EN defined and out_we=1 without it.
